muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the ALU in the execute stage and replaces single-cycle 64-bit operations with a shift-add multiplier and a restoring divider. It exposes `busy` and `stall` outputs so the hazard unit can freeze the front end while an operation is in flight. It adds signed/unsigned modes, divide, `mthi`/`mtlo`, divide-by-zero reporting and abort.

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide: WIDTH iterations, then one fixup cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             rdhiloE,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             divzero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               is_div_q, is_div_d;
  logic               divzero_q, divzero_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               op_mul, op_div, op_signed, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op_mul    = (opE == OP_MULT) | (opE == OP_MULTU);
  assign op_div    = (opE == OP_DIV)  | (opE == OP_DIVU);
  assign op_signed = (opE == OP_MULT) | (opE == OP_DIV);
  assign b_zero    = (srcbE == '0);
  assign abs_a     = (op_signed & srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign abs_b     = (op_signed & srcbE[WIDTH-1]) ? -srcbE : srcbE;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};

  // Divide: acc = {remainder, dividend bits being shifted out / quotient shifted in}.
  // A trial subtraction that would borrow leaves the shifted remainder untouched.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;

  assign prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quot_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    is_div_d  = is_div_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (startE) begin
          divzero_d = op_div & b_zero;
          sign_a_d  = op_signed & srcaE[WIDTH-1];
          sign_b_d  = op_signed & srcbE[WIDTH-1];
          cnt_d     = '0;
          if (op_mul) begin
            state_d  = MUL;
            is_div_d = 1'b0;
            acc_d    = {{WIDTH{1'b0}}, abs_b};
            opnd_d   = abs_a;
          end else if (op_div) begin
            is_div_d = 1'b1;
            opnd_d   = abs_b;
            if (b_zero) begin
              // Raw dividend is kept so the fixup can return it unmodified in HI.
              state_d = FIX;
              acc_d   = {{WIDTH{1'b0}}, srcaE};
            end else begin
              state_d = DIV;
              acc_d   = {{WIDTH{1'b0}}, abs_a};
            end
          end else if (opE == OP_MTHI) begin
            hi_d = srcaE;
          end else if (opE == OP_MTLO) begin
            lo_d = srcaE;
          end
        end
      end
      MUL: begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      DIV: begin
        acc_d = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (divzero_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over a same-cycle writeback; HI/LO keep their old values.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      is_div_q  <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      is_div_q  <= is_div_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q != IDLE);
  assign stall   = busy & (startE | rdhiloE);
  assign done    = done_q;
  assign divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal cases plus randomized traffic vs a timing/arith model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, startE, rdhiloE, abort;
  logic [2:0]   opE;
  logic [W-1:0] srcaE, srcbE, hi, lo;
  logic         busy, stall, done, divzero;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .rdhiloE(rdhiloE), .abort(abort),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .divzero(divzero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} of an op, straight from integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int     sa, sb, q, r;
    pa = $signed(a);
    pb = $signed(b);
    sa = a;
    sb = b;
    case (op)
      3'd0: return pa * pb;
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Model: remaining busy cycles plus the pending result.
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int m_rem = 0;
  bit m_done = 1'b0, m_dz = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (abort) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end
      end else if (startE) begin
        m_dz = (opE == 3'd2 || opE == 3'd3) && srcbE == 0;
        case (opE)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            {p_hi, p_lo} = ref_res(opE, srcaE, srcbE);
            m_rem = m_dz ? 1 : W + 1;
          end
          3'd4: m_hi = srcaE;
          3'd5: m_lo = srcaE;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("done", 64'(done), 64'(m_done));
      check("divzero", 64'(divzero), 64'(m_dz));
      check("stall", 64'(stall), 64'((m_rem > 0) && (startE || rdhiloE)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    step();
    startE = 1'b0; opE = 3'd7;
  endtask

  task automatic run_lit(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_busy, input logic [31:0] eh, input logic [31:0] el);
    int nb;
    bit got;
    issue(op, a, b);
    nb = 0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nb++;
      step();
    end
    check({nm, "_done_seen"}, 64'(got), 64'd1);
    check({nm, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int ns, nb, nd;
    reset = 1'b1; startE = 1'b0; opE = 3'd7; srcaE = '0; srcbE = '0; rdhiloE = 1'b0; abort = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_divzero", 64'(divzero), 64'd0);

    run_lit("mult", 3'd0, 32'hFFFFFFFF, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFE);
    step();
    check("mult_done_once", 64'(done), 64'd0);
    run_lit("multu", 3'd1, 32'hFFFFFFFF, 32'h2, 33, 32'h1, 32'hFFFFFFFE);
    run_lit("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_lit("divu_100_7", 3'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_lit("div_intmin", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
    run_lit("div_by0", 3'd2, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF);
    check("div_by0_flag", 64'(divzero), 64'd1);
    run_lit("multu_3_3", 3'd1, 32'd3, 32'd3, 33, 32'd0, 32'd9);
    check("multu_3_3_flag", 64'(divzero), 64'd0);
    // Started in the done cycle of the previous op.
    run_lit("b2b_divu", 3'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    issue(3'd4, 32'h1234, 32'h0);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(3'd5, 32'h5678, 32'h0);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mtlo_lo", 64'(lo), 64'h5678);

    issue(3'd0, 32'd7, 32'd6);
    startE = 1'b1; opE = 3'd3; srcaE = 32'd100; srcbE = 32'd7; rdhiloE = 1'b1;
    ns = 0; nb = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      nb++;
      if (stall) ns++;
      step();
    end
    startE = 1'b0; opE = 3'd7; rdhiloE = 1'b0;
    check("stall_cycles", 64'(ns), 64'd33);
    check("stall_busy", 64'(nb), 64'd33);
    check("stall_done", 64'(done), 64'd1);
    check("stall_hi", 64'(hi), 64'd0);
    check("stall_lo", 64'(lo), 64'd42);
    step();
    step();
    check("stall_ignored_busy", 64'(busy), 64'd0);
    check("stall_ignored_lo", 64'(lo), 64'd42);

    issue(3'd4, 32'hAAAA, 32'h0);
    issue(3'd5, 32'hAAAA, 32'h0);
    issue(3'd0, 32'd5, 32'd7);
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'hAAAA);
    check("abort_lo", 64'(lo), 64'hAAAA);
    nd = 0;
    repeat (40) begin
      if (done) nd++;
      step();
    end
    check("abort_no_done", 64'(nd), 64'd0);

    run_lit("pre_rst_dz", 3'd3, 32'd9, 32'd0, 1, 32'd9, 32'hFFFFFFFF);
    issue(3'd0, 32'd5, 32'd7);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_hi", 64'(hi), 64'd0);
    check("mrst_lo", 64'(lo), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_divzero", 64'(divzero), 64'd0);

    repeat (3000) begin
      startE  = ($urandom % 4) == 0;
      opE     = 3'($urandom % 8);
      srcaE   = pick();
      srcbE   = pick();
      rdhiloE = ($urandom % 3) == 0;
      abort   = ($urandom % 60) == 0;
      reset   = ($urandom % 500) == 0;
      step();
    end
    startE = 1'b0; rdhiloE = 1'b0; abort = 1'b0; reset = 1'b0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
